uart_tx: RTL and testbench

// - UART transmitter; serialises 8-bit words into the frame format uart_rx consumes.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_baud_tick.sv | 39 +++
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: FSM encodings, word size and
// the parity rule placed ahead of the data bits in each frame.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W      = $clog2(UART_DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam logic PARITY_EVEN = 1'b1;

  function automatic logic frame_parity(input logic [UART_DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    return PARITY_EVEN ? p : ~p;
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Free-running bit-period counter: counts 0..term_i and pulses tick_o on the
// terminal count, then wraps. clear_i holds it at zero.
module uart_tx_baud_tick #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == term_i);

  // next count: clear, wrap at terminal, otherwise increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick_o) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  // counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, even parity, 8 data bits LSB first, stop, then an
// idle gap. A one-word holding register lets the producer queue the next byte.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned clksPerBit = 87,
  parameter int unsigned gapClks    = clksPerBit / 2
) (
  input  logic                      i_clkTx,
  input  logic                      i_rstTxN,
  input  logic                      i_txValid,
  input  logic [UART_DATA_BITS-1:0] i_txBits,
  output logic                      o_txReady,
  output logic                      o_txBit,
  output logic                      o_txBusy,
  output logic                      o_txFinished
);

  localparam int unsigned CNT_MAX = (clksPerBit > gapClks) ? clksPerBit : gapClks;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BIT_TERM = CNT_W'(clksPerBit - 1);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(gapClks - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

  logic [2:0]                state_q,     state_d;
  logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
  logic [UART_DATA_BITS-1:0] hold_q,      hold_d;
  logic                      hold_full_q, hold_full_d;
  logic                      parity_q,    parity_d;
  logic [BIT_IDX_W-1:0]      bit_idx_q,   bit_idx_d;
  logic                      tx_bit_q,    tx_bit_d;
  logic                      busy_q,      busy_d;
  logic                      finished_q,  finished_d;

  logic                      tick_s;
  logic                      cnt_clear_s;
  logic [CNT_W-1:0]          cnt_term_s;

  uart_tx_baud_tick #(.CNT_W(CNT_W)) u_baud_tick (
    .clk_i   (i_clkTx),
    .rst_ni  (i_rstTxN),
    .clear_i (cnt_clear_s),
    .term_i  (cnt_term_s),
    .tick_o  (tick_s)
  );

  // holding-register handshake, frame sequencing and next line level
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    finished_d  = 1'b0;
    cnt_clear_s = 1'b0;
    cnt_term_s  = BIT_TERM;

    if (i_txValid && !hold_full_q) begin
      hold_d      = i_txBits;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_clear_s = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
          parity_d    = frame_parity(hold_q);
          hold_full_d = 1'b0;
          bit_idx_d   = {BIT_IDX_W{1'b0}};
          state_d     = S_START;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) state_d = S_PARITY;
        else        state_d = S_START;
      end
      S_PARITY: begin
        if (tick_s) state_d = S_DATA;
        else        state_d = S_PARITY;
      end
      S_DATA: begin
        if (tick_s) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1'b1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tick_s) state_d = S_GAP;
        else        state_d = S_STOP;
      end
      S_GAP: begin
        cnt_term_s = GAP_TERM;
        if (tick_s) begin
          state_d    = S_IDLE;
          finished_d = 1'b1;
        end else begin
          state_d    = S_GAP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_clear_s = 1'b1;
      end
    endcase

    // line level follows the state being entered so o_txBit stays registered
    case (state_d)
      S_START:  tx_bit_d = 1'b0;
      S_PARITY: tx_bit_d = parity_d;
      S_DATA:   tx_bit_d = shift_d[0];
      default:  tx_bit_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // state and output registers
  always_ff @(posedge i_clkTx or negedge i_rstTxN) begin
    if (!i_rstTxN) begin
      state_q     <= S_IDLE;
      shift_q     <= {UART_DATA_BITS{1'b0}};
      hold_q      <= {UART_DATA_BITS{1'b0}};
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      bit_idx_q   <= {BIT_IDX_W{1'b0}};
      tx_bit_q    <= 1'b1;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      tx_bit_q    <= tx_bit_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

  assign o_txReady    = ~hold_full_q;
  assign o_txBit      = tx_bit_q;
  assign o_txBusy     = busy_q;
  assign o_txFinished = finished_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a reference receiver rebuilds each expected
// frame from the accepted byte and checks the line, busy and finished per cycle.
module tb_uart_tx;

  localparam int CLKS = 16;
  localparam int GAP  = 8;
  localparam int FRAME_CYC = 11 * CLKS + GAP;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_bits;
  logic       tx_ready;
  logic       tx_bit;
  logic       tx_busy;
  logic       tx_finished;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  bit mon_busy = 1'b0;

  uart_tx #(.clksPerBit(CLKS), .gapClks(GAP)) dut (
    .i_clkTx      (clk),
    .i_rstTxN     (rst_n),
    .i_txValid    (tx_valid),
    .i_txBits     (tx_bits),
    .o_txReady    (tx_ready),
    .o_txBit      (tx_bit),
    .o_txBusy     (tx_busy),
    .o_txFinished (tx_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called on a negedge; returns on the negedge after the transfer edge.
  task automatic send(input logic [7:0] b, input bit hold);
    int n = 0;
    tx_valid = 1'b1;
    tx_bits  = b;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check_eq("send_timeout", 32'(n), 32'(0));
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(n >= 1000), 32'(0));
  endtask

  // Reference receiver: entered on the first low cycle of a frame.
  task automatic check_frame();
    logic [7:0]  b;
    logic [10:0] bits;
    int n = 0;
    if (exp_q.size() == 0) begin
      check_eq("frame_unexpected", 32'(1), 32'(0));
      while (tx_bit == 1'b0 && rst_n && n < 2 * FRAME_CYC) begin
        @(negedge clk);
        n++;
      end
      return;
    end
    mon_busy = 1'b1;
    b = exp_q.pop_front();
    bits[0] = 1'b0;
    bits[1] = ^b;
    for (int i = 0; i < 8; i++) bits[2 + i] = b[i];
    bits[10] = 1'b1;
    for (int k = 0; k <= FRAME_CYC; k++) begin
      if (k > 0) @(negedge clk);
      if (!rst_n) begin
        mon_busy = 1'b0;
        return;
      end
      if (k < 11 * CLKS) check_eq("line_bit", 32'(tx_bit), 32'(bits[k / CLKS]));
      else               check_eq("line_gap", 32'(tx_bit), 32'(1));
      check_eq("busy",     32'(tx_busy),     32'(k < FRAME_CYC));
      check_eq("finished", 32'(tx_finished), 32'(k == FRAME_CYC));
    end
    mon_busy = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && tx_bit == 1'b0) check_frame();
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int gap;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_bits  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_bit",      32'(tx_bit),      32'(1));
    check_eq("rst_ready",    32'(tx_ready),    32'(1));
    check_eq("rst_busy",     32'(tx_busy),     32'(0));
    check_eq("rst_finished", 32'(tx_finished), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("idle_bit",   32'(tx_bit),   32'(1));
      check_eq("idle_ready", 32'(tx_ready), 32'(1));
      check_eq("idle_busy",  32'(tx_busy),  32'(0));
    end

    // single frame with latency and ready timing
    send(8'hA5, 1'b0);
    check_eq("lat_pre_bit",   32'(tx_bit),   32'(1));
    check_eq("ready_drop",    32'(tx_ready), 32'(0));
    @(negedge clk);
    check_eq("lat_start_bit", 32'(tx_bit),   32'(0));
    check_eq("ready_back",    32'(tx_ready), 32'(1));
    drain();

    send(8'h07, 1'b0);
    drain();

    // back-to-back with valid held; third byte must stall a whole frame
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    tx_bits = 8'h99;
    n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_len", 32'(n), 32'(FRAME_CYC));
    @(posedge clk);
    exp_q.push_back(8'h99);
    @(negedge clk);
    tx_valid = 1'b0;
    drain();

    // asynchronous reset in the middle of the data bits
    send(8'hFF, 1'b0);
    repeat (60) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_bit",   32'(tx_bit),   32'(1));
    check_eq("arst_busy",  32'(tx_busy),  32'(0));
    check_eq("arst_ready", 32'(tx_ready), 32'(1));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h55, 1'b0);
    drain();

    // randomized bytes with random idle gaps
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'b1);
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
      if (gap > 0) begin
        tx_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    drain();

    // full byte sweep, back-to-back
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1);
    tx_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
